fifo_push_arbiter: RTL and testbench
====================================

FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of each requester and of the FIFO write port.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters.
REQ-003 SHALL have parameter L2N, default 2, log2(NREQ), width of grant index.
REQ-004 SHALL have parameter STALL_LIM, default 7, wait cycles after which stall asserts; max 2^4-1.
REQ-005 SHALL have one clock and an asynchronous, active-low reset (ports listed first below).
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 req  input  NREQ  per-requester push request; bit i belongs to requester i.
REQ-009 req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-010 req_ack  output  NREQ  per-requester acknowledge, one-hot or zero.
REQ-011 fifo_push_req  output  1  push request to FIFO.
REQ-012 fifo_data_in  output  WIDTH  data to FIFO.
REQ-013 fifo_push_ack  input  1  push acknowledge from FIFO.
REQ-014 gnt_valid  output  1  a grant is held (state BUSY).
REQ-015 gnt_id  output  L2N  index of the granted requester.
REQ-016 stall  output  1  granted push waiting STALL_LIM or more cycles without ack.

Function
REQ-017 SHALL implement two states, IDLE and BUSY; gnt_valid = (state==BUSY).
REQ-018 In IDLE with req!=0, SHALL select the first set req bit scanning rr_ptr, rr_ptr+1, ... mod NREQ, and next cycle enter BUSY with gnt_id = winner.
REQ-019 In IDLE with req==0, SHALL stay IDLE; gnt_id holds its last value.
REQ-020 Grant latency: req rising in cycle N SHALL produce fifo_push_req=1 in cycle N+1 (registered, no combinational req->fifo_push_req path).
REQ-021 In BUSY, fifo_push_req SHALL be 1 continuously until the cycle fifo_push_ack=1 (inclusive); it never drops without ack.
REQ-022 In BUSY, fifo_data_in SHALL equal req_data slice gnt_id; in IDLE it SHALL be 0.
REQ-023 req_ack[gnt_id] SHALL equal fifo_push_ack && BUSY combinationally; all other req_ack bits 0.
REQ-024 fifo_push_ack while IDLE SHALL be ignored: no req_ack, no state change.
REQ-025 On BUSY && fifo_push_ack, next cycle SHALL be IDLE and rr_ptr = (gnt_id+1) mod NREQ; one mandatory IDLE cycle between grants (peak 1 push per 2 cycles).
REQ-026 rr_ptr SHALL change only on a completed handshake, wrapping from NREQ-1 to 0.
REQ-027 Grant SHALL be held in BUSY even if req[gnt_id] deasserts (requester protocol violation); other requests SHALL not preempt.
REQ-028 Requesters are constrained to hold req[i] and req_data slice i stable from assertion until req_ack[i]; the block does not register data.
REQ-029 wait_cnt (4-bit) SHALL clear on entry to BUSY and on IDLE, increment each BUSY cycle without fifo_push_ack, saturate at STALL_LIM.
REQ-030 stall SHALL be 1 iff BUSY and wait_cnt == STALL_LIM; cleared the cycle after ack.
REQ-031 FIFO full is not observed; a full FIFO simply withholds fifo_push_ack and the grant waits (stall may assert).
REQ-032 Fairness: with all NREQ requesting continuously, each requester SHALL be granted exactly once in any NREQ consecutive grants.

Reset
REQ-033 On resetn=0, asynchronously: state IDLE, rr_ptr 0, gnt_id 0, wait_cnt 0; outputs req_ack 0, fifo_push_req 0, fifo_data_in 0, gnt_valid 0, stall 0.
REQ-034 Reset mid-BUSY SHALL abandon the pending push with no req_ack; first grant after release starts from rr_ptr 0.

Verification
REQ-035 Reset release, req=4'b0100, data2=8'hA5, ack one cycle after push_req -> push_req next cycle, fifo_data_in=A5, req_ack=4'b0100, rr_ptr=3.
REQ-036 req=4'b1111 held, ack always 1 -> gnt_id sequence 0,1,2,3,0 with one IDLE cycle between grants.
REQ-037 rr_ptr=3, req=4'b1001 -> gnt_id=3 first, then 0.
REQ-038 Grant held, ack withheld 9 cycles -> stall=1 from 7th wait cycle, push_req stays 1, data stable; ack -> stall 0 next cycle.
REQ-039 resetn low while BUSY -> all outputs 0 immediately, no req_ack; after release req=4'b1010 -> gnt_id=1.
REQ-040 fifo_push_ack pulsed while IDLE, req=0 -> req_ack stays 0, state IDLE.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter funnelling NREQ push requesters into a single FIFO write port.
// One grant at a time; the grant is held until the FIFO acknowledges the push.
module fifo_push_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned L2N       = 2,
    parameter int unsigned STALL_LIM = 7
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ack,
    output logic                  fifo_push_req,
    output logic [WIDTH-1:0]      fifo_data_in,
    input  logic                  fifo_push_ack,
    output logic                  gnt_valid,
    output logic [L2N-1:0]        gnt_id,
    output logic                  stall
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e         state_q, state_d;
    logic [L2N-1:0] gnt_id_q, gnt_id_d;
    logic [L2N-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]     wait_cnt_q, wait_cnt_d;
    logic [L2N-1:0] win_id;
    logic           win_found;
    logic           busy;

    // Scan requests starting at rr_ptr; the first set bit wins.
    always_comb begin
        int unsigned    idx;
        logic [L2N-1:0] idx_l;
        win_id    = '0;
        win_found = 1'b0;
        idx       = 0;
        idx_l     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx   = (32'(rr_ptr_q) + i) % NREQ;
            idx_l = idx[L2N-1:0];
            if (!win_found && req[idx_l]) begin
                win_found = 1'b1;
                win_id    = idx_l;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle: begin
                wait_cnt_d = '0;
                if (win_found) begin
                    state_d  = StBusy;
                    gnt_id_d = win_id;
                end
            end
            StBusy: begin
                if (fifo_push_ack) begin
                    state_d    = StIdle;
                    wait_cnt_d = '0;
                    rr_ptr_d   = (gnt_id_q == L2N'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;
                end else if (wait_cnt_q != 4'(STALL_LIM)) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            gnt_id_q   <= '0;
            rr_ptr_q   <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            rr_ptr_q   <= rr_ptr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Every output is decoded from registered state; only req_ack sees the FIFO ack.
    always_comb begin
        busy          = (state_q == StBusy);
        gnt_valid     = busy;
        gnt_id        = gnt_id_q;
        fifo_push_req = busy;
        fifo_data_in  = busy ? req_data[32'(gnt_id_q)*WIDTH +: WIDTH] : '0;
        req_ack       = '0;
        if (busy && fifo_push_ack) begin
            req_ack[gnt_id_q] = 1'b1;
        end
        stall = busy && (wait_cnt_q == 4'(STALL_LIM));
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: per-cycle vector table plus hand-written
// sequences for round-robin rotation, stall saturation and reset mid-grant.
module tb_fifo_push_arbiter;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ack;
    logic           fifo_push_req;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_push_ack = 1'b0;
    logic           gnt_valid;
    logic [1:0]     gnt_id;
    logic           stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_push_arbiter #(.WIDTH(W), .NREQ(N), .L2N(2), .STALL_LIM(7)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req          (req),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .fifo_push_req(fifo_push_req),
        .fifo_data_in (fifo_data_in),
        .fifo_push_ack(fifo_push_ack),
        .gnt_valid    (gnt_valid),
        .gnt_id       (gnt_id),
        .stall        (stall)
    );

    typedef struct {
        logic [N-1:0] req;
        logic         ack;
        logic         e_push;
        logic [N-1:0] e_rack;
        logic [1:0]   e_gid;
        logic [W-1:0] e_din;
        logic         e_stall;
    } vec_t;

    // slice3=3C slice2=A5 slice1=51 slice0=E7
    localparam logic [N*W-1:0] DATA = 32'h3CA5_51E7;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic push, input logic [N-1:0] rack,
                              input logic [1:0] gid, input logic [W-1:0] din, input logic st);
        check({tag, ".push_req"}, 32'(fifo_push_req), 32'(push));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(push));
        check({tag, ".req_ack"}, 32'(req_ack), 32'(rack));
        check({tag, ".gnt_id"}, 32'(gnt_id), 32'(gid));
        check({tag, ".data"}, 32'(fifo_data_in), 32'(din));
        check({tag, ".stall"}, 32'(stall), 32'(st));
    endtask

    // Drive one cycle at the falling edge, sample 2 time units later.
    task automatic cycle(input logic [N-1:0] r, input logic a);
        @(negedge clk);
        req           = r;
        fifo_push_ack = a;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn        = 1'b0;
        req           = '0;
        fifo_push_ack = 1'b0;
        #2;
        check_outs("reset", 1'b0, '0, 2'd0, '0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0};
        vecs[1]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 8'hA5, 1'b0};
        vecs[2]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 8'h00, 1'b0};
        vecs[3]  = '{4'b1001, 1'b0, 1'b0, 4'b0000, 2'd2, 8'h00, 1'b0};
        vecs[4]  = '{4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3, 8'h3C, 1'b0};
        vecs[5]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 2'd3, 8'h00, 1'b0};
        vecs[6]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 8'hE7, 1'b0};
        vecs[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0};
        vecs[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0};
        vecs[9]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0};
        vecs[10] = '{4'b0010, 1'b0, 1'b1, 4'b0000, 2'd1, 8'h51, 1'b0};
        // Requester drops early; the grant must be held until acked.
        vecs[11] = '{4'b0000, 1'b1, 1'b1, 4'b0010, 2'd1, 8'h51, 1'b0};
        vecs[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 8'h00, 1'b0};

        req_data = DATA;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].req, vecs[i].ack);
            check_outs($sformatf("vec%0d", i), vecs[i].e_push, vecs[i].e_rack,
                       vecs[i].e_gid, vecs[i].e_din, vecs[i].e_stall);
        end

        // All four requesting, FIFO always ready: grants 0,1,2,3,0 with IDLE between.
        do_reset();
        begin
            logic [1:0] exp_seq[5];
            logic [1:0] last;
            exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
            last = 2'd0;
            for (int k = 0; k < 10; k++) begin
                cycle(4'b1111, 1'b1);
                if (k % 2 == 1) begin
                    last = exp_seq[k/2];
                    check_outs($sformatf("rr%0d", k), 1'b1, 4'(1) << last, last,
                               DATA[32'(last)*W +: W], 1'b0);
                end else begin
                    check_outs($sformatf("rr%0d", k), 1'b0, '0, last, '0, 1'b0);
                end
            end
        end

        // Grant held with ack withheld 9 cycles; stall after 7 wait cycles.
        do_reset();
        cycle(4'b0000, 1'b0);
        cycle(4'b0100, 1'b0);
        check_outs("st_idle", 1'b0, '0, 2'd0, '0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            cycle(4'b0100, 1'b0);
            check_outs($sformatf("st_wait%0d", k), 1'b1, '0, 2'd2, 8'hA5, k >= 8);
        end
        cycle(4'b0100, 1'b1);
        check_outs("st_ack", 1'b1, 4'b0100, 2'd2, 8'hA5, 1'b1);
        cycle(4'b0000, 1'b0);
        check_outs("st_after", 1'b0, '0, 2'd2, '0, 1'b0);

        // rr_ptr is now 3: grant requester 3, then reset mid-BUSY.
        cycle(4'b1000, 1'b0);
        cycle(4'b1000, 1'b0);
        check_outs("rb_busy", 1'b1, '0, 2'd3, 8'h3C, 1'b0);
        fifo_push_ack = 1'b1;
        resetn = 1'b0;
        #1;
        check_outs("rb_rst", 1'b0, '0, 2'd0, '0, 1'b0);
        @(negedge clk);
        resetn        = 1'b1;
        fifo_push_ack = 1'b0;
        req           = 4'b1010;
        #2;
        check_outs("rb_idle", 1'b0, '0, 2'd0, '0, 1'b0);
        cycle(4'b1010, 1'b0);
        check_outs("rb_gnt", 1'b1, '0, 2'd1, 8'h51, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
